// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared types and constants for the MIPS pipeline memory stage.
//   mem_state_t         : data-memory sequencer states (IDLE, REQ, WAIT, DONE)
//   MEM_ERR_DATA        : load data returned when an access times out
//   MEM_TIMEOUT_DEFAULT : default cycle budget per handshake phase
// ---------------------------------------------------------------------------
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } mem_state_t;

  localparam logic [31:0] MEM_ERR_DATA        = 32'hDEADBEEF;
  localparam int          MEM_TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/mem_timeout_cnt.sv
// ---------------------------------------------------------------------------
// mem_timeout_cnt
// Saturating cycle counter that bounds one handshake phase of the data-memory
// sequencer.
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset
//   i_clear   : restart the count (entry into a new phase)
//   i_enable  : count this cycle
//   o_expired : count has reached TIMEOUT; holds until cleared
// ---------------------------------------------------------------------------
module mem_timeout_cnt #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_cnt <= '0;
    end else if (i_enable && !o_expired) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expired = (r_cnt == LIMIT);

endmodule

// File: rtl/dmem_stall_ctrl.sv
// ---------------------------------------------------------------------------
// dmem_stall_ctrl
// MEM-stage data-memory sequencer. Turns the load/store of the instruction in
// MEM into a req/gnt/rvalid handshake and freezes the pipeline (mem_stall)
// until the access completes, then releases it for exactly one cycle.
//
// Build option: define MEM_TIMEOUT_EN to bound each handshake phase to
// TIMEOUT cycles; on expiry the access is abandoned, loads return
// MEM_ERR_DATA and mem_err pulses for one cycle. Without it the sequencer
// waits indefinitely and has no mem_err port.
//
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   load_MEM, MemWrite_MEM : instruction in MEM is a load / store
//   Addr_MEM, WD_MEM, BE_MEM : address, store data, byte enables
//   mem_stall              : pipeline freeze (combinational)
//   RD_MEM                 : registered load data, valid in DONE
//   mem_req/we/addr/wdata/be : registered memory request bus
//   mem_gnt, mem_rvalid, mem_rdata : memory responses
//   mem_err                : timeout pulse (MEM_TIMEOUT_EN only)
// ---------------------------------------------------------------------------
module dmem_stall_ctrl
  import mips_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_MEM,
  input  logic            MemWrite_MEM,
  input  logic [AW-1:0]   Addr_MEM,
  input  logic [DW-1:0]   WD_MEM,
  input  logic [DW/8-1:0] BE_MEM,
  output logic            mem_stall,
  output logic [DW-1:0]   RD_MEM,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_be,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [DW-1:0]   mem_rdata
`ifdef MEM_TIMEOUT_EN
  ,
  output logic            mem_err
`endif
);

  mem_state_t r_state, w_next;

  logic            r_req, r_we;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_wdata, r_rd;
  logic [DW/8-1:0] r_be;

  logic w_access, w_we_in, w_load_done, w_err, w_tmo;

  // A simultaneous load and store is treated as a load.
  assign w_access = load_MEM | MemWrite_MEM;
  assign w_we_in  = MemWrite_MEM & ~load_MEM;

`ifdef MEM_TIMEOUT_EN
  logic w_cnt_clr, w_cnt_en, r_err;

  // Restart the budget on entry to REQ (from IDLE) and to WAIT (from REQ).
  assign w_cnt_clr = ((r_state == IDLE) && w_access) ||
                     ((r_state == REQ) && (w_next == WAIT));
  assign w_cnt_en  = (r_state == REQ) || (r_state == WAIT);

  mem_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_cnt_clr),
    .i_enable  (w_cnt_en),
    .o_expired (w_tmo)
  );

  always_ff @(posedge clk) begin
    if (rst) r_err <= 1'b0;
    else     r_err <= w_err;
  end

  assign mem_err = r_err;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT != 0);
  assign w_tmo            = 1'b0;
`endif

  always_comb begin
    w_next      = r_state;
    w_load_done = 1'b0;
    w_err       = 1'b0;
    mem_stall   = 1'b0;
    case (r_state)
      IDLE: begin
        mem_stall = w_access;
        if (w_access) w_next = REQ;
      end
      REQ: begin
        mem_stall = 1'b1;
        // rvalid before gnt belongs to nothing we issued; only honour it
        // together with or after the grant.
        if (mem_gnt) begin
          if (r_we) begin
            w_next = DONE;
          end else if (mem_rvalid) begin
            w_next      = DONE;
            w_load_done = 1'b1;
          end else begin
            w_next = WAIT;
          end
        end else if (w_tmo) begin
          w_next = DONE;
          w_err  = 1'b1;
        end
      end
      WAIT: begin
        mem_stall = 1'b1;
        if (mem_rvalid) begin
          w_next      = DONE;
          w_load_done = 1'b1;
        end else if (w_tmo) begin
          w_next = DONE;
          w_err  = 1'b1;
        end
      end
      // Release cycle: always back to IDLE without looking at access, so the
      // instruction still sitting in MEM is not issued a second time.
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_rd    <= '0;
    end else begin
      r_state <= w_next;
      r_req   <= (w_next == REQ);
      if ((r_state == IDLE) && w_access) begin
        r_we    <= w_we_in;
        r_addr  <= Addr_MEM;
        r_wdata <= WD_MEM;
        r_be    <= BE_MEM;
      end
      if (w_load_done)       r_rd <= mem_rdata;
      else if (w_err && !r_we) r_rd <= DW'(MEM_ERR_DATA);
    end
  end

  assign mem_req   = r_req;
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_be    = r_be;
  assign RD_MEM    = r_rd;

endmodule

// File: doc/dmem_stall_ctrl.md
Name: dmem_stall_ctrl

Overview:
- Data-memory access sequencer in the MEM stage; the producer of `mem_stall`, which freezes IF/ID, ID/EX and EX/MEM while an access is outstanding.
- Converts the single-cycle load/store request of the instruction in MEM into a req/gnt/rvalid handshake with an external memory.
- Returns registered load data to the MEM/WB path.
- Releases the pipeline for exactly one cycle per completed access.

Parameters:
- AW, 32, address width.
- DW, 32, data width. Byte enables are DW/8 bits.
- TIMEOUT, 255, cycles allowed per handshake phase. Used only with MEM_TIMEOUT_EN.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- load_MEM  in  1  the instruction in MEM is a load.
- MemWrite_MEM  in  1  the instruction in MEM is a store.
- Addr_MEM  in  AW  byte address, the ALU result.
- WD_MEM  in  DW  store data.
- BE_MEM  in  DW/8  byte enables.
- mem_stall  out  1  freeze the pipeline; this is the mem_stall input of the pipeline registers.
- RD_MEM  out  DW  load data, valid while in DONE.
- mem_req  out  1  memory request.
- mem_we  out  1  request is a write.
- mem_addr  out  AW  request address.
- mem_wdata  out  DW  write data.
- mem_be  out  DW/8  byte enables.
- mem_gnt  in  1  request accepted.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  DW  read data.
- mem_err  out  1  one-cycle timeout pulse. Present only with MEM_TIMEOUT_EN.

Behaviour:
- access = load_MEM | MemWrite_MEM. If both are high, treat it as a load and ignore the store.
- State machine has four states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - mem_stall = access, combinationally.
  - If access, capture addr, wdata, be and we (= MemWrite_MEM & ~load_MEM) into registers, then go to REQ.
  - No mem_req is driven in IDLE.
- REQ:
  - mem_req = 1 and mem_stall = 1. The bus outputs come from the captured registers and stay stable until gnt.
  - On gnt with we = 1: go to DONE.
  - On gnt with we = 0 and mem_rvalid also high in the same cycle: latch rdata, go to DONE.
  - On gnt with we = 0 otherwise: go to WAIT.
  - mem_rvalid seen before gnt is ignored.
- WAIT:
  - mem_req = 0, mem_stall = 1.
  - On mem_rvalid: latch mem_rdata into RD_MEM, go to DONE.
- DONE:
  - mem_stall = 0 for this one cycle, so the pipeline advances and MEM/WB samples RD_MEM.
  - Always go to IDLE. The access is not re-evaluated, which prevents re-issue of the same instruction.
  - A memory op arriving next is handled in IDLE on the following cycle.
- RD_MEM holds its value until the next load completes. Stores leave RD_MEM unchanged.
- Minimum latencies, counted in stalled cycles:
  - Store: 2 (IDLE, REQ with gnt at once), then the DONE release cycle.
  - Load: 2 with gnt and rvalid together, or 3 with rvalid one cycle after gnt, then DONE.
  - Every access costs at least one release cycle, so back-to-back memory ops are serviced at best every 3 cycles.
- Reset values: state IDLE, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, mem_be 0, RD_MEM 0, mem_err 0.
  - mem_stall follows its combinational rule (1 only if access is high in IDLE).
- Reset in REQ or WAIT:
  - Drops the request at once and returns to IDLE.
  - A late mem_rvalid arriving in IDLE or REQ is discarded.
- Bus outputs are registered. mem_stall is combinational from state and access.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- With the macro:
  - A counter clears on entry to REQ or WAIT and increments each cycle while in REQ or WAIT without completion.
  - When the counter reaches TIMEOUT, drop mem_req, set RD_MEM = 32'hDEADBEEF (for loads), pulse mem_err for one cycle, and go to DONE.
- Without the macro: there is no counter, no mem_err port, and the block waits indefinitely.

Decomposition:
- mips_pkg gains:
  - mem_state_t (IDLE, REQ, WAIT, DONE).
  - MEM_ERR_DATA = 32'hDEADBEEF.
  - MEM_TIMEOUT_DEFAULT = 255.
- One sub-module, mem_timeout_cnt (clear, enable, expired), instantiated only under MEM_TIMEOUT_EN.

Test Plan:
- Store at 0x0000_0010, data 0xCAFEBABE, BE 4'hF, gnt in the first REQ cycle:
  - mem_stall high for 2 cycles, then low for 1.
  - Exactly one mem_req with mem_we 1, addr 0x10, wdata 0xCAFEBABE.
- Load at 0x20, gnt after 3 cycles, rvalid 2 cycles later with rdata 0x12345678:
  - mem_stall high 7 cycles.
  - In DONE: mem_stall 0 and RD_MEM 0x12345678.
  - Single request only.
- Load followed immediately by a store, both with zero-wait gnt/rvalid:
  - Two distinct requests.
  - mem_stall sequence 1,1,0,1,1,0.
  - No duplicate issue.
- rvalid pulsed while in REQ before gnt, then gnt + rvalid together with rdata 0xA5A5A5A5:
  - The early rvalid is ignored.
  - RD_MEM = 0xA5A5A5A5.
- rst asserted while in WAIT, then rvalid arrives:
  - Next cycle: state IDLE, mem_req 0, RD_MEM 0.
  - The late rvalid does not change RD_MEM.
- With MEM_TIMEOUT_EN and TIMEOUT = 4, load with gnt never asserted:
  - mem_err pulses once.
  - RD_MEM = 0xDEADBEEF.
  - mem_stall drops for one cycle.
